// File: rtl/regfile_fwd.sv
// Two-read/one-write register file with WB bypass and optional EX/MEM forwarding plus load-use stall.
// Define REGFILE_FWD_EN to build in EX/MEM forwarding and stallreq_o; otherwise those inputs are ignored.
module regfile_fwd #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [4:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [4:0]        raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [4:0]        raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic              ex_wreg_i,
    input  logic [4:0]        ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              mem_wreg_i,
    input  logic [4:0]        mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              ex_is_load_i,
    output logic              stallreq_o
);

    logic [DATA_W-1:0] regs [REG_NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (we_i && waddr_i != '0) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    // Youngest producer wins: EX, then MEM, then WB, then the array.
    function automatic logic [DATA_W-1:0] resolve(
        input logic              re,
        input logic [4:0]        ra,
        input logic [DATA_W-1:0] arr_val
    );
        if (rst || !re || ra == '0) return '0;
`ifdef REGFILE_FWD_EN
        if (ex_wreg_i && ex_wd_i == ra) return ex_wdata_i;
        if (mem_wreg_i && mem_wd_i == ra) return mem_wdata_i;
`endif
        if (we_i && waddr_i == ra) return wdata_i;
        return arr_val;
    endfunction

    always_comb begin
        rdata1_o = resolve(re1_i, raddr1_i, regs[raddr1_i]);
        rdata2_o = resolve(re2_i, raddr2_i, regs[raddr2_i]);
    end

`ifdef REGFILE_FWD_EN
    assign stallreq_o = !rst && ex_is_load_i && ex_wreg_i && ex_wd_i != '0 &&
                        ((re1_i && raddr1_i == ex_wd_i) || (re2_i && raddr2_i == ex_wd_i));
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_wreg_i, ex_wd_i, ex_wdata_i, mem_wreg_i, mem_wd_i,
                          mem_wdata_i, ex_is_load_i};
    assign stallreq_o = 1'b0;
`endif

endmodule
